// File: rtl/add_issue_pkg.sv
// add_issue_pkg: widths and response record shared by the add issue block
// and its return / tag FIFOs.
package add_issue_pkg;

   localparam int OPND_W = 64;
   localparam int HTID_W = 9;

   // One adder result waiting to be handed back to its thread.
   typedef struct packed {
      logic [OPND_W-1:0] res;
      logic [HTID_W-1:0] htId;
   } rsp_t;

   localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/add_issue_rfifo.sv
// add_issue_rfifo: synchronous FIFO with occupancy count. The head entry is
// visible combinationally and reads as zero while the FIFO is empty, so
// reset leaves every data output at 0. A push into a full FIFO is dropped
// unless a pop frees the slot in the same cycle; a pop of an empty FIFO is
// ignored.
module add_issue_rfifo
   import add_issue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = RSP_W,
   parameter int CNT_W = 7
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             i_push,
   input  logic [W-1:0]     i_din,
   input  logic             i_pop,
   output logic [W-1:0]     o_dout,
   output logic             o_empty,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_count = r_count;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array; contents are only observable through the masked head.
   always_ff @(posedge ck) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push & ~w_pop)      r_count <= r_count + CNT_W'(1);
         else if (~w_push & w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/add_issue.sv
// add_issue: issues thread operand pairs to an adder wrapper and returns the
// results to the threads in arrival order through a credited return buffer.
// Optional feature macro: ADD_ISSUE_HTID_CHK_EN adds an in-order tag FIFO of
// issued htIds and flags a returned htId that does not match its head.
//
// Handshakes: req and rsp transfer on a cycle where valid and ready are both
// high; valid never depends on ready. o_req_rdy is combinational from the
// credit state and i_add_rdy only. The add issue and add result paths are
// single-cycle pulses with no backpressure; space for every result is
// reserved by the credit rule (outstanding + buffered < RET_DEPTH) at the
// time the request is accepted.
module add_issue
   import add_issue_pkg::*;
#(
   parameter int RET_DEPTH = 16,
   parameter int CNT_W     = 7
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              i_req_vld,
   input  logic [OPND_W-1:0] i_req_a,
   input  logic [OPND_W-1:0] i_req_b,
   input  logic [HTID_W-1:0] i_req_htId,
   output logic              o_req_rdy,
   output logic              o_add_vld,
   output logic [OPND_W-1:0] o_add_a,
   output logic [OPND_W-1:0] o_add_b,
   output logic [HTID_W-1:0] o_add_htId,
   input  logic              i_add_rdy,
   input  logic              i_add_vld,
   input  logic [OPND_W-1:0] i_add_res,
   input  logic [HTID_W-1:0] i_add_htId,
   output logic              o_rsp_vld,
   output logic [OPND_W-1:0] o_rsp_res,
   output logic [HTID_W-1:0] o_rsp_htId,
   input  logic              i_rsp_rdy,
   output logic [CNT_W-1:0]  o_outstanding,
   output logic              o_err
);

   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(RET_DEPTH);

   logic              r_add_vld;
   logic [OPND_W-1:0] r_add_a;
   logic [OPND_W-1:0] r_add_b;
   logic [HTID_W-1:0] r_add_htId;
   logic [CNT_W-1:0]  r_outstanding;
   logic              r_err;

   logic [CNT_W:0]    w_credit_used;
   logic [CNT_W-1:0]  w_ret_count;
   logic              w_ret_empty;
   logic              w_ret_full;
   rsp_t              w_ret_din;
   rsp_t              w_ret_dout;
   logic              w_accept;
   logic              w_inc;
   logic              w_dec;
   logic              w_tag_err;
   logic              w_err_set;

   // Credits in use: results still in the adder plus results waiting here.
   assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_ret_count};
   assign o_req_rdy     = rst & i_add_rdy & (w_credit_used < CREDIT_MAX);
   assign w_accept      = i_req_vld & o_req_rdy;

   assign w_inc = w_accept;
   // A result with nothing outstanding is a protocol error; the count holds at 0.
   assign w_dec = i_add_vld & (r_outstanding != '0);

   // Capture accepted operands; the issue pulse lasts one cycle and the
   // operand registers keep the last issued values in between.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_add_vld  <= 1'b0;
         r_add_a    <= '0;
         r_add_b    <= '0;
         r_add_htId <= '0;
      end else begin
         r_add_vld <= w_accept;
         if (w_accept) begin
            r_add_a    <= i_req_a;
            r_add_b    <= i_req_b;
            r_add_htId <= i_req_htId;
         end
      end
   end

   // Outstanding count: up on accept, down on result, unchanged on both.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_outstanding <= '0;
      end else if (w_inc & ~w_dec) begin
         r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (~w_inc & w_dec) begin
         r_outstanding <= r_outstanding - CNT_W'(1);
      end
   end

`ifdef ADD_ISSUE_HTID_CHK_EN
   logic [HTID_W-1:0] w_tag_head;
   logic              w_tag_empty;
   logic              w_tag_full;
   logic [CNT_W-1:0]  w_tag_count;
   logic              w_unused_tag;

   // Tags of issued requests, in issue order; the adder returns in order.
   add_issue_rfifo #(
      .DEPTH (RET_DEPTH),
      .W     (HTID_W),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .ck      (ck),
      .rst     (rst),
      .i_push  (w_accept),
      .i_din   (i_req_htId),
      .i_pop   (i_add_vld),
      .o_dout  (w_tag_head),
      .o_empty (w_tag_empty),
      .o_full  (w_tag_full),
      .o_count (w_tag_count)
   );

   assign w_unused_tag = ^{w_tag_full, w_tag_count};
   assign w_tag_err    = i_add_vld & (w_tag_empty | (w_tag_head != i_add_htId));
`else
   assign w_tag_err    = 1'b0;
`endif

   assign w_err_set = (i_add_vld & (r_outstanding == '0)) | w_tag_err;

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
   end

   assign w_ret_din.res  = i_add_res;
   assign w_ret_din.htId = i_add_htId;

   add_issue_rfifo #(
      .DEPTH (RET_DEPTH),
      .W     (RSP_W),
      .CNT_W (CNT_W)
   ) u_ret_fifo (
      .ck      (ck),
      .rst     (rst),
      .i_push  (i_add_vld),
      .i_din   (w_ret_din),
      .i_pop   (i_rsp_rdy),
      .o_dout  (w_ret_dout),
      .o_empty (w_ret_empty),
      .o_full  (w_ret_full),
      .o_count (w_ret_count)
   );

   logic w_unused_ret;
   assign w_unused_ret = w_ret_full;

   assign o_add_vld     = r_add_vld;
   assign o_add_a       = r_add_a;
   assign o_add_b       = r_add_b;
   assign o_add_htId    = r_add_htId;
   assign o_rsp_vld     = ~w_ret_empty;
   assign o_rsp_res     = w_ret_dout.res;
   assign o_rsp_htId    = w_ret_dout.htId;
   assign o_outstanding = r_outstanding;
   assign o_err         = r_err;

endmodule

// File: tb/tb_add_issue.sv
// tb_add_issue: randomized bench for add_issue with an in-order adder model
// and a transaction-level reference (credits = accepted - popped).
`timescale 1ns/1ps
module tb_add_issue;
   import add_issue_pkg::*;

   localparam int RET_DEPTH = 16;
   localparam int CNT_W     = 7;
   localparam int RW        = OPND_W + HTID_W;

   // ---------------- clock / reset ----------------
   logic ck  = 1'b0;
   logic rst = 1'b1;
   always #5 ck = ~ck;

   logic              i_req_vld = 1'b0;
   logic [OPND_W-1:0] i_req_a = '0;
   logic [OPND_W-1:0] i_req_b = '0;
   logic [HTID_W-1:0] i_req_htId = '0;
   logic              o_req_rdy;
   logic              o_add_vld;
   logic [OPND_W-1:0] o_add_a;
   logic [OPND_W-1:0] o_add_b;
   logic [HTID_W-1:0] o_add_htId;
   logic              i_add_rdy = 1'b0;
   logic              i_add_vld = 1'b0;
   logic [OPND_W-1:0] i_add_res = '0;
   logic [HTID_W-1:0] i_add_htId = '0;
   logic              o_rsp_vld;
   logic [OPND_W-1:0] o_rsp_res;
   logic [HTID_W-1:0] o_rsp_htId;
   logic              i_rsp_rdy = 1'b0;
   logic [CNT_W-1:0]  o_outstanding;
   logic              o_err;

   add_issue #(.RET_DEPTH(RET_DEPTH), .CNT_W(CNT_W)) dut (
      .ck(ck), .rst(rst),
      .i_req_vld(i_req_vld), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_htId(i_req_htId),
      .o_req_rdy(o_req_rdy),
      .o_add_vld(o_add_vld), .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_htId(o_add_htId),
      .i_add_rdy(i_add_rdy),
      .i_add_vld(i_add_vld), .i_add_res(i_add_res), .i_add_htId(i_add_htId),
      .o_rsp_vld(o_rsp_vld), .o_rsp_res(o_rsp_res), .o_rsp_htId(o_rsp_htId), .i_rsp_rdy(i_rsp_rdy),
      .o_outstanding(o_outstanding), .o_err(o_err)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_acc = 0;

   logic [RW-1:0]     exp_q[$];      // expected responses {res, htId}
   logic [HTID_W-1:0] tag_q[$];      // issued htIds awaiting return
   logic [OPND_W-1:0] add_res_q[$];  // adder model pipeline
   logic [HTID_W-1:0] add_ht_q[$];
   int                add_due_q[$];
   int                last_due = 0;

   int                m_out = 0;
   bit                m_err = 1'b0;
   bit                m_iss_vld = 1'b0;
   logic [OPND_W-1:0] m_iss_a = '0;
   logic [OPND_W-1:0] m_iss_b = '0;
   logic [HTID_W-1:0] m_iss_ht = '0;
   bit                spur = 1'b0;
   bit                bump = 1'b0;
   int                force_ht = -1;

   task automatic clear_model();
      m_out = 0;
      m_err = 1'b0;
      m_iss_vld = 1'b0;
      m_iss_a = '0;
      m_iss_b = '0;
      m_iss_ht = '0;
      exp_q.delete();
      tag_q.delete();
   endtask

   // ---------------- driver: cycle engine with model ----------------
   // Entered and left at posedge+1. pct arguments are percentages.
   task automatic run_cycles(input int n, input int req_pct, input int ardy_pct,
                             input int rrdy_pct, input int lat_lo, input int lat_hi);
      bit acc;
      bit pop;
      bit mrdy;
      int due;
      for (int k = 0; k < n; k++) begin
         n_cmp++;
         if (o_add_vld !== m_iss_vld || o_add_a !== m_iss_a || o_add_b !== m_iss_b ||
             o_add_htId !== m_iss_ht) begin
            n_err++;
            $display("FAIL add_issue cyc=%0d got vld=%0b a=%h b=%h ht=%0d exp vld=%0b a=%h b=%h ht=%0d",
                     cyc, o_add_vld, o_add_a, o_add_b, o_add_htId, m_iss_vld, m_iss_a, m_iss_b, m_iss_ht);
         end
         n_cmp++;
         if (o_outstanding !== CNT_W'(m_out)) begin
            n_err++;
            $display("FAIL outstanding cyc=%0d got %0d exp %0d", cyc, o_outstanding, m_out);
         end
         n_cmp++;
         if (o_rsp_vld !== (exp_q.size() != 0) ||
             (exp_q.size() != 0 && {o_rsp_res, o_rsp_htId} !== exp_q[0])) begin
            n_err++;
            $display("FAIL rsp cyc=%0d got vld=%0b res=%h ht=%0d exp vld=%0b head=%h",
                     cyc, o_rsp_vld, o_rsp_res, o_rsp_htId, exp_q.size() != 0,
                     (exp_q.size() != 0) ? exp_q[0] : '0);
         end
         n_cmp++;
         if (o_err !== m_err) begin
            n_err++;
            $display("FAIL err cyc=%0d got %0b exp %0b", cyc, o_err, m_err);
         end
         // adder model picks up the issue it sees this cycle
         if (m_iss_vld) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due < last_due) due = last_due;
            last_due = due;
            add_res_q.push_back(m_iss_a + m_iss_b);
            add_ht_q.push_back(bump ? m_iss_ht + 9'd1 : m_iss_ht);
            add_due_q.push_back(due);
            bump = 1'b0;
         end
         // drive inputs
         i_req_vld  = ($urandom_range(99, 0) < req_pct);
         i_req_a    = {$urandom, $urandom};
         i_req_b    = {$urandom, $urandom};
         i_req_htId = (force_ht >= 0) ? HTID_W'(force_ht) : HTID_W'($urandom_range(511, 0));
         i_add_rdy  = ($urandom_range(99, 0) < ardy_pct);
         i_rsp_rdy  = ($urandom_range(99, 0) < rrdy_pct);
         if (add_due_q.size() != 0 && add_due_q[0] <= cyc) begin
            i_add_vld  = 1'b1;
            i_add_res  = add_res_q.pop_front();
            i_add_htId = add_ht_q.pop_front();
            void'(add_due_q.pop_front());
         end else if (spur) begin
            i_add_vld  = 1'b1;
            i_add_res  = {$urandom, $urandom};
            i_add_htId = HTID_W'($urandom_range(511, 0));
            spur = 1'b0;
         end else begin
            i_add_vld  = 1'b0;
            i_add_res  = {$urandom, $urandom};
            i_add_htId = HTID_W'($urandom_range(511, 0));
         end
         #1;
         mrdy = i_add_rdy && (m_out + exp_q.size() < RET_DEPTH);
         n_cmp++;
         if (o_req_rdy !== mrdy) begin
            n_err++;
            $display("FAIL req_rdy cyc=%0d got %0b exp %0b", cyc, o_req_rdy, mrdy);
         end
         // model state update
         acc = i_req_vld && mrdy;
         pop = i_rsp_rdy && (exp_q.size() != 0);
         if (pop) void'(exp_q.pop_front());
         if (i_add_vld) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
`ifdef ADD_ISSUE_HTID_CHK_EN
            if (tag_q.size() == 0 || tag_q[0] != i_add_htId) m_err = 1'b1;
            if (tag_q.size() != 0) void'(tag_q.pop_front());
`endif
            if (exp_q.size() < RET_DEPTH) exp_q.push_back({i_add_res, i_add_htId});
         end
         if (acc) begin
            m_out++;
            n_acc++;
            m_iss_a  = i_req_a;
            m_iss_b  = i_req_b;
            m_iss_ht = i_req_htId;
            tag_q.push_back(i_req_htId);
         end
         m_iss_vld = acc;
         @(posedge ck);
         #1;
         cyc++;
      end
   endtask

   task automatic pulse_reset();
      #2;
      rst = 1'b0;
      i_req_vld = 1'b0;
      i_add_vld = 1'b0;
      i_rsp_rdy = 1'b0;
      i_add_rdy = 1'b0;
      @(posedge ck);
      #3;
      rst = 1'b1;
      @(posedge ck);
      #1;
      clear_model();
      add_res_q.delete();
      add_ht_q.delete();
      add_due_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      i_req_vld = 1'b1;
      i_add_rdy = 1'b1;
      i_add_vld = 1'b1;
      i_rsp_rdy = 1'b1;
      i_add_res = 64'hdead;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge ck);
         #1;
         n_cmp++;
         if ({o_add_vld, o_rsp_vld, o_req_rdy, o_err} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctl got add_vld=%0b rsp_vld=%0b req_rdy=%0b err=%0b exp 0",
                     o_add_vld, o_rsp_vld, o_req_rdy, o_err);
         end
         n_cmp++;
         if (o_outstanding !== '0 || o_add_a !== '0 || o_add_b !== '0 || o_add_htId !== '0 ||
             o_rsp_res !== '0 || o_rsp_htId !== '0) begin
            n_err++;
            $display("FAIL reset_data got outst=%0d a=%h b=%h ht=%0d res=%h rht=%0d exp 0",
                     o_outstanding, o_add_a, o_add_b, o_add_htId, o_rsp_res, o_rsp_htId);
         end
      end
      i_req_vld = 1'b0;
      i_add_vld = 1'b0;
      i_rsp_rdy = 1'b0;
      #3;
      rst = 1'b1;
      @(posedge ck);
      #1;
      clear_model();
   endtask

   task automatic test_single();
      i_add_rdy = 1'b1;
      i_rsp_rdy = 1'b0;
      i_add_vld = 1'b0;
      i_req_vld = 1'b1;
      i_req_a = 64'd1;
      i_req_b = 64'd2;
      i_req_htId = 9'd5;
      #1;
      n_cmp++;
      if (o_req_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL single_rdy got %0b exp 1", o_req_rdy);
      end
      @(posedge ck);
      #1;
      i_req_vld = 1'b0;
      n_cmp++;
      if (o_add_vld !== 1'b1 || o_add_a !== 64'd1 || o_add_b !== 64'd2 || o_add_htId !== 9'd5 ||
          o_outstanding !== CNT_W'(1)) begin
         n_err++;
         $display("FAIL single_issue got vld=%0b a=%0d b=%0d ht=%0d outst=%0d exp 1/1/2/5/1",
                  o_add_vld, o_add_a, o_add_b, o_add_htId, o_outstanding);
      end
      @(posedge ck);
      #1;
      n_cmp++;
      if (o_add_vld !== 1'b0 || o_add_a !== 64'd1 || o_add_b !== 64'd2 || o_add_htId !== 9'd5) begin
         n_err++;
         $display("FAIL single_hold got vld=%0b a=%0d b=%0d ht=%0d exp 0/1/2/5",
                  o_add_vld, o_add_a, o_add_b, o_add_htId);
      end
      i_add_vld = 1'b1;
      i_add_res = 64'd3;
      i_add_htId = 9'd5;
      @(posedge ck);
      #1;
      i_add_vld = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (o_rsp_vld !== 1'b1 || o_rsp_res !== 64'd3 || o_rsp_htId !== 9'd5 ||
             o_outstanding !== '0) begin
            n_err++;
            $display("FAIL single_rsp got vld=%0b res=%0d ht=%0d outst=%0d exp 1/3/5/0",
                     o_rsp_vld, o_rsp_res, o_rsp_htId, o_outstanding);
         end
         @(posedge ck);
         #1;
      end
      i_rsp_rdy = 1'b1;
      @(posedge ck);
      #1;
      i_rsp_rdy = 1'b0;
      n_cmp++;
      if (o_rsp_vld !== 1'b0 || o_err !== 1'b0) begin
         n_err++;
         $display("FAIL single_pop got rsp_vld=%0b err=%0b exp 0/0", o_rsp_vld, o_err);
      end
      m_iss_a = 64'd1;
      m_iss_b = 64'd2;
      m_iss_ht = 9'd5;
   endtask

   task automatic test_stall();
      int base;
      base = n_acc;
      run_cycles(8, 100, 0, 100, 1, 1);
      n_cmp++;
      if (n_acc - base !== 0) begin
         n_err++;
         $display("FAIL stall_accepts got %0d exp 0", n_acc - base);
      end
   endtask

   task automatic test_full();
      int base;
      base = n_acc;
      run_cycles(30, 100, 100, 0, 1, 1);
      n_cmp++;
      if (n_acc - base !== RET_DEPTH) begin
         n_err++;
         $display("FAIL full_accepts got %0d exp %0d", n_acc - base, RET_DEPTH);
      end
      run_cycles(1, 0, 100, 100, 1, 1);
      base = n_acc;
      run_cycles(1, 100, 100, 0, 1, 1);
      n_cmp++;
      if (n_acc - base !== 1) begin
         n_err++;
         $display("FAIL full_reopen got %0d exp 1", n_acc - base);
      end
      run_cycles(40, 0, 100, 100, 1, 1);
   endtask

   task automatic test_back_to_back();
      int base;
      base = n_acc;
      run_cycles(110, 100, 100, 100, 1, 1);
      n_cmp++;
      if (n_acc - base !== 110) begin
         n_err++;
         $display("FAIL b2b_accepts got %0d exp 110", n_acc - base);
      end
      run_cycles(10, 0, 100, 100, 1, 1);
   endtask

   task automatic test_random();
      run_cycles(600, 60, 80, 50, 1, 6);
      run_cycles(60, 0, 100, 100, 1, 1);
      n_cmp++;
      if (o_outstanding !== '0 || o_rsp_vld !== 1'b0) begin
         n_err++;
         $display("FAIL random_drain got outst=%0d rsp_vld=%0b exp 0/0", o_outstanding, o_rsp_vld);
      end
   endtask

   task automatic test_err();
      bit exp_tag_err;
      spur = 1'b1;
      run_cycles(6, 0, 100, 100, 1, 1);
      n_cmp++;
      if (o_err !== 1'b1) begin
         n_err++;
         $display("FAIL err_spurious got %0b exp 1", o_err);
      end
      pulse_reset();
      force_ht = 7;
      bump = 1'b1;
      run_cycles(1, 100, 100, 100, 1, 1);
      force_ht = -1;
      run_cycles(6, 0, 100, 100, 1, 1);
`ifdef ADD_ISSUE_HTID_CHK_EN
      exp_tag_err = 1'b1;
`else
      exp_tag_err = 1'b0;
`endif
      n_cmp++;
      if (o_err !== exp_tag_err) begin
         n_err++;
         $display("FAIL err_tag got %0b exp %0b", o_err, exp_tag_err);
      end
      pulse_reset();
   endtask

   task automatic test_reset_mid();
      logic [OPND_W-1:0] sv_res[$];
      logic [HTID_W-1:0] sv_ht[$];
      run_cycles(4, 100, 100, 0, 20, 20);
      run_cycles(1, 0, 100, 0, 20, 20);
      n_cmp++;
      if (o_outstanding !== CNT_W'(4)) begin
         n_err++;
         $display("FAIL mid_outst got %0d exp 4", o_outstanding);
      end
      i_add_rdy = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({o_add_vld, o_rsp_vld, o_req_rdy, o_err} !== 4'b0 || o_outstanding !== '0 ||
          o_add_a !== '0 || o_add_b !== '0 || o_add_htId !== '0 ||
          o_rsp_res !== '0 || o_rsp_htId !== '0) begin
         n_err++;
         $display("FAIL mid_async got add_vld=%0b rsp_vld=%0b rdy=%0b err=%0b outst=%0d a=%h exp all 0",
                  o_add_vld, o_rsp_vld, o_req_rdy, o_err, o_outstanding, o_add_a);
      end
      @(posedge ck);
      #3;
      rst = 1'b1;
      @(posedge ck);
      #1;
      clear_model();
      sv_res = add_res_q;
      sv_ht = add_ht_q;
      add_res_q.delete();
      add_ht_q.delete();
      add_due_q.delete();
      last_due = 0;
      run_cycles(8, 100, 100, 100, 1, 1);
      run_cycles(10, 0, 100, 100, 1, 1);
      n_cmp++;
      if (o_err !== 1'b0) begin
         n_err++;
         $display("FAIL mid_clean got err=%0b exp 0", o_err);
      end
      // results that were in flight at reset now come back
      foreach (sv_res[k]) begin
         add_res_q.push_back(sv_res[k]);
         add_ht_q.push_back(sv_ht[k]);
         add_due_q.push_back(cyc);
      end
      run_cycles(12, 0, 100, 100, 1, 1);
      n_cmp++;
      if (o_err !== 1'b1) begin
         n_err++;
         $display("FAIL mid_late got err=%0b exp 1", o_err);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_stall();
      test_full();
      test_back_to_back();
      test_random();
      test_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/add_issue.md
ADD_ISSUE -- requirements
Module: add_issue

Interface
REQ-001 SHALL have parameter RET_DEPTH, default 16, return-buffer entries (power of 2, 4..64).
REQ-002 SHALL have parameter CNT_W, default 7, width of outstanding/occupancy counters (>= log2(RET_DEPTH)+1).
REQ-003 SHALL have port ck  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have ports i_req_vld in 1 / i_req_a in 64 / i_req_b in 64 / i_req_htId in 9 -- thread operand request.
REQ-006 SHALL have port o_req_rdy  out  1  request accepted when i_req_vld & o_req_rdy.
REQ-007 SHALL have ports o_add_vld out 1 / o_add_a out 64 / o_add_b out 64 / o_add_htId out 9 -- issue to adder wrapper.
REQ-008 SHALL have port i_add_rdy  in  1  adder wrapper entry not almost-full.
REQ-009 SHALL have ports i_add_vld in 1 / i_add_res in 64 / i_add_htId in 9 -- adder result, no backpressure.
REQ-010 SHALL have ports o_rsp_vld out 1 / o_rsp_res out 64 / o_rsp_htId out 9 / i_rsp_rdy in 1 -- thread response, valid/ready.
REQ-011 SHALL have ports o_outstanding out CNT_W (issued, not returned) and o_err out 1 (sticky protocol error).

Function
REQ-012 SHALL assert o_req_rdy = i_add_rdy & (outstanding + ret_count < RET_DEPTH), combinational, no dependence on i_req_vld.
REQ-013 SHALL register an accepted request and drive o_add_vld high for exactly one cycle in the next cycle with captured a/b/htId; latency 1.
REQ-014 SHALL hold o_add_a/b/htId stable when o_add_vld is low (last issued value).
REQ-015 SHALL increment outstanding on acceptance and decrement on i_add_vld; both same cycle leaves it unchanged.
REQ-016 SHALL push {i_add_res, i_add_htId} into the return buffer every cycle i_add_vld is high; credit rule REQ-012 guarantees space.
REQ-017 SHALL present return-buffer head with o_rsp_vld high the cycle after push into empty buffer (latency 1), FIFO order.
REQ-018 SHALL pop on o_rsp_vld & i_rsp_rdy; simultaneous push and pop keeps ret_count; pop of last + push same cycle keeps o_rsp_vld high with new data next cycle.
REQ-019 SHALL hold o_rsp_res/o_rsp_htId stable while o_rsp_vld & !i_rsp_rdy.
REQ-020 SHALL set o_err on i_add_vld while outstanding == 0 (counter saturates at 0, data still pushed only if space, else dropped).
REQ-021 SHALL never deadlock: with i_rsp_rdy held high and i_add_rdy high, one request per cycle sustained.

Reset
REQ-022 SHALL, while rst low, force o_add_vld=0, o_rsp_vld=0, o_req_rdy=0, o_err=0, o_outstanding=0, buffer empty, data outputs 0.
REQ-023 SHALL discard in-flight state on reset mid-operation; results arriving after reset release with outstanding==0 set o_err.

Configuration
REQ-024 SHALL, with ADD_ISSUE_HTID_CHK_EN defined, keep an in-order tag FIFO of issued htIds (depth RET_DEPTH) and set o_err when i_add_htId differs from the expected head.
REQ-025 SHALL, without ADD_ISSUE_HTID_CHK_EN, omit the tag FIFO; o_err set only per REQ-020.

Structure
REQ-026 SHALL take OPND_W=64, HTID_W=9 and the response struct {res, htId} from shared package add_issue_pkg.
REQ-027 SHALL implement the return buffer as sub-module add_issue_rfifo (sync FIFO, async active-low reset, count output); tag FIFO reuses it.

Verification
REQ-028 Single req a=1,b=2,htId=5, adder returns res=3,htId=5 at cycle N -> o_add_vld one cycle after accept, o_rsp_vld at N+1 with 3/5, o_outstanding 1 then 0.
REQ-029 RET_DEPTH=16, i_rsp_rdy=0, results returned -> exactly 16 accepted, o_req_rdy low after 16th; one pop re-raises o_req_rdy next cycle.
REQ-030 i_add_rdy=0 with i_req_vld high -> o_req_rdy=0, no o_add_vld, counters unchanged.
REQ-031 Simultaneous accept, i_add_vld and pop at steady state -> o_outstanding and ret_count unchanged, 100 back-to-back ops in order.
REQ-032 i_add_vld with outstanding 0 -> o_err=1 sticky until reset; with ADD_ISSUE_HTID_CHK_EN, issue htId 7 return htId 8 -> o_err=1.
REQ-033 rst low mid-stream with 4 outstanding -> all outputs to reset values asynchronously, clean operation after release.
